burst_write_fifo_master: RTL

- Avalon-MM burst write master; the downstream partner of the burst read master.
- Accepts a stream of words into an internal FIFO and writes them to memory as a run of bursts covering a programmed length.
- A read master's ctrl_readdata / ctrl_readdatavalid output drives user_writedata / user_write directly.
- Completion is signalled on a ctrl-side busy/done handshake.

---
 rtl/burst_master_pkg.sv | 24 ++
 rtl/burst_write_fifo_master_if.sv | 43 ++++
 rtl/sc_fifo_showahead.sv | 55 +++++
 rtl/burst_write_fifo_master.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/burst_master_pkg.sv
// Shared definitions for the burst read/write FIFO masters: state encoding
// and small sizing helpers.
package burst_master_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_LOAD     = 5'b00010,
    ST_WAITFILL = 5'b00100,
    ST_BURST    = 5'b01000,
    ST_FINISH   = 5'b10000
  } state_e;

  localparam int unsigned BITS_PER_BYTE = 8;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / BITS_PER_BYTE;
  endfunction

  function automatic int unsigned min_burst(input int unsigned remaining,
                                            input int unsigned max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/burst_write_fifo_master_if.sv
// Control, user-stream and Avalon-MM signals of the burst write master.
interface burst_write_fifo_master_if #(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned BYTE_ENABLE_WIDTH = 4,
  parameter int unsigned LENGTH_WIDTH      = 16,
  parameter int unsigned BURST_WIDTH       = 4
);
  logic                         ctrl_start;
  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress;
  logic [LENGTH_WIDTH-1:0]      ctrl_length;
  logic                         ctrl_busy;
  logic                         ctrl_done;
  logic                         user_write;
  logic [DATA_WIDTH-1:0]        user_writedata;
  logic                         user_full;
  logic [ADDRESS_WIDTH-1:0]     master_address;
  logic                         master_write;
  logic [DATA_WIDTH-1:0]        master_writedata;
  logic [BURST_WIDTH-1:0]       master_burstcount;
  logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
  logic                         master_waitrequest;

  modport master (
    input  ctrl_start, ctrl_baseaddress, ctrl_length,
    output ctrl_busy, ctrl_done,
    input  user_write, user_writedata,
    output user_full,
    output master_address, master_write, master_writedata,
    output master_burstcount, master_byteenable,
    input  master_waitrequest
  );

  modport slave (
    output ctrl_start, ctrl_baseaddress, ctrl_length,
    input  ctrl_busy, ctrl_done,
    output user_write, user_writedata,
    input  user_full,
    input  master_address, master_write, master_writedata,
    input  master_burstcount, master_byteenable,
    output master_waitrequest
  );
endinterface

// File: rtl/sc_fifo_showahead.sv
// Single-clock show-ahead FIFO: dout always presents the head entry.
module sc_fifo_showahead #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     full,
  output logic                     empty
);
  logic [DATA_WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]     count_q, count_d;
  logic                         push_ok, pop_ok;

  assign full    = (count_q == (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/burst_write_fifo_master.sv
// Avalon-MM burst write master: drains a show-ahead FIFO to memory as a run
// of bursts; each burst starts only once all its beats are buffered.
module burst_write_fifo_master
  import burst_master_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned BYTE_ENABLE_WIDTH = 4,
  parameter int unsigned LENGTH_WIDTH      = 16,
  parameter int unsigned MAX_BURST         = 8,
  parameter int unsigned BURST_WIDTH       = 4,
  parameter int unsigned FIFO_DEPTH        = 32,
  parameter int unsigned FIFO_DEPTH_LOG2   = 5
) (
  input logic                      clk,
  input logic                      reset,
  burst_write_fifo_master_if.master bus
);
  localparam int unsigned WORD_BYTES = bytes_per_word(DATA_WIDTH);

  state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_reg_q, addr_reg_d;
  logic [ADDRESS_WIDTH-1:0]   master_address_q, master_address_d;
  logic [LENGTH_WIDTH-1:0]    remaining_q, remaining_d;
  logic [BURST_WIDTH-1:0]     burst_len_q, burst_len_d;
  logic [BURST_WIDTH-1:0]     beat_q, beat_d;
  logic [BURST_WIDTH-1:0]     master_burstcount_q, master_burstcount_d;
  logic                       master_write_q, master_write_d;
  logic                       ctrl_busy_q, ctrl_busy_d;
  logic                       ctrl_done_q, ctrl_done_d;

  logic [DATA_WIDTH-1:0]      fifo_dout;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count;
  logic                       fifo_full, fifo_empty;
  logic                       beat_accept;

  assign beat_accept = master_write_q && !bus.master_waitrequest;

  sc_fifo_showahead #(
    .DATA_WIDTH      (DATA_WIDTH),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.user_write),
    .pop   (beat_accept && !fifo_empty),
    .din   (bus.user_writedata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d             = state_q;
    addr_reg_d          = addr_reg_q;
    master_address_d    = master_address_q;
    remaining_d         = remaining_q;
    burst_len_d         = burst_len_q;
    beat_d              = beat_q;
    master_burstcount_d = master_burstcount_q;
    master_write_d      = master_write_q;
    ctrl_busy_d         = ctrl_busy_q;
    ctrl_done_d         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_start) begin
          addr_reg_d  = bus.ctrl_baseaddress;
          remaining_d = bus.ctrl_length;
          ctrl_busy_d = 1'b1;
          state_d     = (bus.ctrl_length == '0) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        burst_len_d = BURST_WIDTH'(min_burst(32'(remaining_q), MAX_BURST));
        state_d     = ST_WAITFILL;
      end
      ST_WAITFILL: begin
        if (32'(fifo_count) >= 32'(burst_len_q)) begin
          master_write_d      = 1'b1;
          master_address_d    = addr_reg_q;
          master_burstcount_d = burst_len_q;
          beat_d              = '0;
          state_d             = ST_BURST;
        end
      end
      ST_BURST: begin
        if (beat_accept) begin
          beat_d = beat_q + BURST_WIDTH'(1);
          if (beat_q == burst_len_q - BURST_WIDTH'(1)) begin
            master_write_d = 1'b0;
            addr_reg_d     = addr_reg_q
                             + ADDRESS_WIDTH'(burst_len_q) * ADDRESS_WIDTH'(WORD_BYTES);
            remaining_d    = remaining_q - LENGTH_WIDTH'(burst_len_q);
            state_d        = (remaining_d != '0) ? ST_LOAD : ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        ctrl_done_d = 1'b1;
        ctrl_busy_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      addr_reg_q          <= '0;
      master_address_q    <= '0;
      remaining_q         <= '0;
      burst_len_q         <= '0;
      beat_q              <= '0;
      master_burstcount_q <= '0;
      master_write_q      <= 1'b0;
      ctrl_busy_q         <= 1'b0;
      ctrl_done_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      addr_reg_q          <= addr_reg_d;
      master_address_q    <= master_address_d;
      remaining_q         <= remaining_d;
      burst_len_q         <= burst_len_d;
      beat_q              <= beat_d;
      master_burstcount_q <= master_burstcount_d;
      master_write_q      <= master_write_d;
      ctrl_busy_q         <= ctrl_busy_d;
      ctrl_done_q         <= ctrl_done_d;
    end
  end

  assign bus.ctrl_busy         = ctrl_busy_q;
  assign bus.ctrl_done         = ctrl_done_q;
  assign bus.user_full         = fifo_full;
  assign bus.master_address    = master_address_q;
  assign bus.master_write      = master_write_q;
  assign bus.master_writedata  = fifo_dout;
  assign bus.master_burstcount = master_burstcount_q;
  assign bus.master_byteenable = {BYTE_ENABLE_WIDTH{1'b1}};
endmodule
